eq_output_limiter: RTL and testbench
====================================

# eq_output_limiter

Stereo output limiter between the two equalizer channels and the audio controller's DAC write port. It captures each equalized left/right sample pair on a strobe, scales both by a shared adaptive gain, hard-clips to a threshold, and holds the result until the controller allows a write. Dropped input pairs are counted for debug. It replaces the direct equalizer-to-controller connection in the top level.

## Interface
Parameters:
- DW, 32, sample width (signed two's complement)
- THRESH, 32'h3000_0000, positive clip/limit threshold
- ATTACK_SHIFT, 2, gain reduction step = gain >> ATTACK_SHIFT
- RELEASE_DIV, 256, cycles between +1 gain release steps

Ports:
- CLOCK_50  in  1  system clock; one clock only
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe: l_in/r_in valid
- l_in  in  DW  left sample from equalizer
- r_in  in  DW  right sample from equalizer
- out_allowed  in  1  controller audio_out_allowed
- l_out  out  DW  limited left sample (registered)
- r_out  out  DW  limited right sample (registered)
- out_write  out  1  write strobe to controller
- gain  out  9  current gain, Q1.8 (256 = unity)
- drop_cnt  out  16  dropped-pair count, saturating
- busy  out  1  high when state != IDLE

## Operation
- States: IDLE, MULT, CHECK, HOLD.
- IDLE: when in_valid is high, register l_in and r_in, then go to MULT.
- MULT:
  - l_g = (l_in × gain) >>> 8, computed at 41-bit width and truncated to DW.
  - r_g is computed the same way. Go to CHECK.
- CHECK:
  - a = |l_g|, b = |r_g|. |−2^(DW−1)| saturates to 2^(DW−1)−1. peak = max(a, b).
  - Each output is clamped to [−THRESH, +THRESH] and registered into l_out/r_out.
  - If peak > THRESH: gain ← gain − max(gain >> ATTACK_SHIFT, 1), floored at 1, and the release counter clears.
  - Go to HOLD.
- HOLD: out_write = out_allowed (combinational). The state returns to IDLE on the edge where out_write is high.
- Release: a counter increments every cycle in any state.
  - When it reaches RELEASE_DIV−1 and gain < 256: gain += 1 and the counter clears.
  - An attack in CHECK on the same cycle takes precedence. The counter clears and no release is applied.
- Drop: in_valid while busy discards that pair. drop_cnt increments and saturates at 16'hFFFF. Gain is unaffected.
- Reset (asynchronous, any state):
  - State goes to IDLE; l_out = r_out = 0; out_write = 0.
  - gain = 256, drop_cnt = 0, release counter = 0, busy = 0.
  - A pair in flight is lost and not counted.

## Timing
- in_valid high at edge E0 → MULT. E1 → CHECK. E2 → l_out/r_out/gain updated, HOLD.
- Earliest out_write is in the cycle after E2, i.e. 3 cycles after in_valid. l_out/r_out are stable throughout HOLD.
- out_allowed low stalls in HOLD indefinitely. No timeout.
- in_valid in the same cycle as out_write (HOLD→IDLE edge) counts as a drop. Capture happens only in IDLE.
- Throughput: one pair per 4 cycles minimum. This is far above the audio sample rate.

## Configuration
- EQ_LIMITER_AGC_EN defined: adaptive attack and release gain as described.
- Undefined:
  - gain is constant 256 and the release counter is removed.
  - MULT passes the samples unscaled; the block acts as a hard clipper plus handshake.
  - gain still reads 256. Latency is unchanged (4-state FSM kept).

## Test plan
- Reset mid-HOLD with out_allowed=0 → out_write=0, l_out=r_out=0, gain=256, busy=0 immediately, asynchronously.
- l_in=32'h1000_0000, r_in=−32'h0800_0000, out_allowed=1 → out_write 3 cycles after in_valid, l_out=32'h1000_0000, r_out=−32'h0800_0000, gain=256.
- l_in=32'h7FFF_FFFF, AGC on → l_out=32'h3000_0000, gain 256→192. A second identical pair gives gain=144. After 256 idle cycles, gain=145.
- l_in=32'h8000_0000 → l_out=−32'h3000_0000, no overflow; peak treated as 32'h7FFF_FFFF and attack applies.
- out_allowed=0 for 20 cycles, 3 in_valid strobes during HOLD → drop_cnt=3, l_out unchanged; out_write when out_allowed rises.
- EQ_LIMITER_AGC_EN undefined, repeated full-scale input → gain stays 256, every output is clipped to ±THRESH.

Source files
------------

// File: rtl/eq_output_limiter.sv
// Stereo limiter between the equalizer and the DAC write port: scale, hard-clip, hold for handshake.
// Define EQ_LIMITER_AGC_EN for adaptive attack/release gain; otherwise gain is fixed at unity.
module eq_output_limiter #(
  parameter int              DW           = 32,
  parameter logic [DW-1:0]   THRESH       = DW'(32'h3000_0000),
  parameter int              ATTACK_SHIFT = 2,
  parameter int              RELEASE_DIV  = 256
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] l_in,
  input  logic signed [DW-1:0] r_in,
  input  logic                 out_allowed,
  output logic signed [DW-1:0] l_out,
  output logic signed [DW-1:0] r_out,
  output logic                 out_write,
  output logic [8:0]           gain,
  output logic [15:0]          drop_cnt,
  output logic                 busy
);

  localparam logic signed [DW-1:0] POS_LIM = $signed(THRESH);
  localparam logic signed [DW-1:0] NEG_LIM = -POS_LIM;
  localparam logic [8:0]           UNITY   = 9'd256;

  if (ATTACK_SHIFT < 0 || ATTACK_SHIFT > 8 || RELEASE_DIV < 2) begin : g_bad_cfg
    $error("eq_output_limiter: ATTACK_SHIFT must be 0..8 and RELEASE_DIV >= 2");
  end

  typedef enum logic [1:0] {IDLE, MULT, CHECK, HOLD} state_t;
  state_t state, state_nxt;

  function automatic logic signed [DW-1:0] clip(input logic signed [DW-1:0] x);
    if (x > POS_LIM) return POS_LIM;
    if (x < NEG_LIM) return NEG_LIM;
    return x;
  endfunction

  logic signed [DW-1:0] l_p0, r_p0, l_p1, r_p1;
  logic signed [DW-1:0] l_sc, r_sc;

`ifdef EQ_LIMITER_AGC_EN
  localparam logic signed [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam int                   CNT_W   = $clog2(RELEASE_DIV);
  localparam logic [CNT_W-1:0]     REL_LAST = CNT_W'(RELEASE_DIV - 1);

  // Q1.8 multiply; with gain <= 256 the shifted product always fits back into DW bits.
  function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] x,
                                                 input logic [8:0] g);
    logic signed [DW+8:0] prod;
    prod = $signed({{9{x[DW-1]}}, x}) * $signed({{DW{1'b0}}, g});
    return DW'(prod >>> 8);
  endfunction

  function automatic logic signed [DW-1:0] abs_sat(input logic signed [DW-1:0] x);
    if (x == {1'b1, {(DW-1){1'b0}}}) return MAX_POS;
    return x[DW-1] ? -x : x;
  endfunction

  function automatic logic [8:0] attack_gain(input logic [8:0] g);
    logic [8:0] step;
    step = g >> ATTACK_SHIFT;
    if (step == '0) step = 9'd1;
    return (g > step) ? g - step : 9'd1;
  endfunction

  logic [8:0]           gain_q;
  logic [CNT_W-1:0]     rel_cnt;
  logic signed [DW-1:0] l_mag, r_mag, peak;
  logic                 attack;

  assign gain  = gain_q;
  assign l_sc  = scale(l_p0, gain_q);
  assign r_sc  = scale(r_p0, gain_q);
  assign l_mag = abs_sat(l_p1);
  assign r_mag = abs_sat(r_p1);
  assign peak  = (r_mag > l_mag) ? r_mag : l_mag;
  assign attack = (state == CHECK) && (peak > POS_LIM);

  // Attack wins over a release step landing on the same cycle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      gain_q  <= UNITY;
      rel_cnt <= '0;
    end else if (attack) begin
      gain_q  <= attack_gain(gain_q);
      rel_cnt <= '0;
    end else if (rel_cnt == REL_LAST) begin
      rel_cnt <= '0;
      if (gain_q < UNITY) gain_q <= gain_q + 9'd1;
    end else begin
      rel_cnt <= rel_cnt + CNT_W'(1);
    end
  end
`else
  assign gain = UNITY;
  assign l_sc = l_p0;
  assign r_sc = r_p0;
`endif

  // p0: capture in IDLE; p1: scaled sample latched in MULT
  always_ff @(posedge CLOCK_50) begin
    if (state == IDLE && in_valid) begin
      l_p0 <= l_in;
      r_p0 <= r_in;
    end
    if (state == MULT) begin
      l_p1 <= l_sc;
      r_p1 <= r_sc;
    end
  end

  // Output stage: clipped samples latched in CHECK, held through HOLD
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      l_out <= '0;
      r_out <= '0;
    end else if (state == CHECK) begin
      l_out <= clip(l_p1);
      r_out <= clip(r_p1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_write = 1'b0;
    case (state)
      IDLE:  if (in_valid) state_nxt = MULT;
      MULT:  state_nxt = CHECK;
      CHECK: state_nxt = HOLD;
      HOLD: begin
        out_write = out_allowed;
        if (out_allowed) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)                                          drop_cnt <= '0;
    else if (in_valid && busy && drop_cnt != 16'hFFFF)   drop_cnt <= drop_cnt + 16'd1;
  end

endmodule

// File: tb/tb_eq_output_limiter.sv
// Directed bench for eq_output_limiter; expected values adapt to EQ_LIMITER_AGC_EN.
module tb_eq_output_limiter;
  localparam int DW = 32;
`ifdef EQ_LIMITER_AGC_EN
  localparam bit AGC = 1'b1;
`else
  localparam bit AGC = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_allowed = 1'b0;
  logic [DW-1:0] l_in = '0;
  logic [DW-1:0] r_in = '0;
  logic [DW-1:0] l_out, r_out;
  logic          out_write, busy;
  logic [8:0]    gain;
  logic [15:0]   drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  eq_output_limiter dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .in_valid    (in_valid),
    .l_in        (l_in),
    .r_in        (r_in),
    .out_allowed (out_allowed),
    .l_out       (l_out),
    .r_out       (r_out),
    .out_write   (out_write),
    .gain        (gain),
    .drop_cnt    (drop_cnt),
    .busy        (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic run_pair(input string tag, input logic [31:0] l, input logic [31:0] r,
                          input logic [31:0] el, input logic [31:0] er, input logic [8:0] eg);
    l_in = l; r_in = r; in_valid = 1'b1; out_allowed = 1'b1;
    step();
    in_valid = 1'b0;
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_wr0"}, 32'(out_write), 32'd0);
    step();
    check_val({tag, "_wr1"}, 32'(out_write), 32'd0);
    step();
    check_val({tag, "_wr"}, 32'(out_write), 32'd1);
    check_val({tag, "_l"}, l_out, el);
    check_val({tag, "_r"}, r_out, er);
    check_val({tag, "_gain"}, 32'(gain), 32'(eg));
    step();
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check_val("rst_wr", 32'(out_write), 32'd0);
    check_val("rst_l", l_out, 32'd0);
    check_val("rst_gain", 32'(gain), 32'd256);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1;
    step();

    run_pair("pass", 32'h1000_0000, 32'hF800_0000, 32'h1000_0000, 32'hF800_0000, 9'd256);
    run_pair("negfs", 32'h8000_0000, 32'h0000_0000, 32'hD000_0000, 32'h0000_0000,
             AGC ? 9'd192 : 9'd256);

    // Stall in HOLD, then reset asynchronously between clock edges
    out_allowed = 1'b0; l_in = 32'h7FFF_FFFF; r_in = 32'h7FFF_FFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_val("hold_busy", 32'(busy), 32'd1);
    check_val("hold_stall", 32'(out_write), 32'd0);
    check_val("hold_l", l_out, 32'h3000_0000);
    #2 reset = 1'b0;
    #1;
    check_val("arst_wr", 32'(out_write), 32'd0);
    check_val("arst_l", l_out, 32'd0);
    check_val("arst_r", r_out, 32'd0);
    check_val("arst_gain", 32'(gain), 32'd256);
    check_val("arst_busy", 32'(busy), 32'd0);
    #3 reset = 1'b1;
    step();

    run_pair("fs1", 32'h7FFF_FFFF, 32'h8000_0001, 32'h3000_0000, 32'hD000_0000,
             AGC ? 9'd192 : 9'd256);
    run_pair("fs2", 32'h7FFF_FFFF, 32'h8000_0001, 32'h3000_0000, 32'hD000_0000,
             AGC ? 9'd144 : 9'd256);
`ifdef EQ_LIMITER_AGC_EN
    repeat (254) step();
    check_val("rel_pre", 32'(gain), 32'd144);
    step();
    check_val("rel_step", 32'(gain), 32'd145);
`endif

    // Drops while stalled in HOLD, plus one on the HOLD->IDLE edge
    out_allowed = 1'b0; l_in = 32'h0100_0000; r_in = 32'h0200_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_val("drp_l0", l_out, AGC ? 32'h0091_0000 : 32'h0100_0000);
    check_val("drp_r0", r_out, AGC ? 32'h0122_0000 : 32'h0200_0000);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 3 || i == 9 || i == 15);
      l_in = 32'h7FFF_FFFF; r_in = 32'h8000_0000;
      step();
    end
    in_valid = 1'b0;
    check_val("drp_cnt3", 32'(drop_cnt), 32'd3);
    check_val("drp_l", l_out, AGC ? 32'h0091_0000 : 32'h0100_0000);
    check_val("drp_r", r_out, AGC ? 32'h0122_0000 : 32'h0200_0000);
    check_val("drp_wr0", 32'(out_write), 32'd0);
    check_val("drp_gain", 32'(gain), AGC ? 32'd145 : 32'd256);
    out_allowed = 1'b1; in_valid = 1'b1;
    #1;
    check_val("drp_wr", 32'(out_write), 32'd1);
    step();
    in_valid = 1'b0;
    check_val("drp_cnt4", 32'(drop_cnt), 32'd4);
    check_val("drp_nocap", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
